upcounter_ctrl: RTL and testbench

Run controller for the team's 4-bit up counter. It latches a start value, terminal value, prescale ratio and mode, then advances the count at the prescaled rate. It reports terminal-count events and supports pause, stop and auto-reload. It sits between the board-level control logic (buttons/FSM) and the counter display path, replacing the free-running counter when sequenced counting is required.

---
 rtl/upcounter_ctrl.sv | 125 ++++++++++++
 tb/tb_upcounter_ctrl.sv | 151 +++++++++++++++
 2 files changed

// File: rtl/upcounter_ctrl.sv
// Sequenced run controller for the 4-bit up counter: start/terminal/prescale/mode latched on start.
// count_out, tick and done are registered; busy is decoded from the registered state.
module upcounter_ctrl #(
  parameter int WIDTH = 4,
  parameter int PRE_W = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic             stop,
  input  logic             pause,
  input  logic             mode,
  input  logic [WIDTH-1:0] load_val,
  input  logic [WIDTH-1:0] term_val,
  input  logic [PRE_W-1:0] prescale,
  output logic [WIDTH-1:0] count_out,
  output logic             tick,
  output logic             done,
  output logic             busy,
  output logic [1:0]       state
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RUN    = 2'd1,
    ST_PAUSED = 2'd2,
    ST_DONE   = 2'd3
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] count_q, count_d;
  logic [WIDTH-1:0] load_q, load_d;
  logic [WIDTH-1:0] term_q, term_d;
  logic [PRE_W-1:0] pre_q, pre_d;
  logic [PRE_W-1:0] presc_q, presc_d;
  logic             mode_q, mode_d;
  logic             tick_q, tick_d;
  logic             done_q, done_d;

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    load_d  = load_q;
    term_d  = term_q;
    pre_d   = pre_q;
    presc_d = presc_q;
    mode_d  = mode_q;
    tick_d  = 1'b0;
    done_d  = 1'b0;

    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (stop && (state_q == ST_DONE)) begin
          state_d = ST_IDLE;
        end else if (start) begin
          load_d  = load_val;
          term_d  = term_val;
          presc_d = prescale;
          mode_d  = mode;
          count_d = load_val;
          pre_d   = '0;
          state_d = ST_RUN;
        end
      end
      default: begin
        // RUN and PAUSED share this path; the release edge out of PAUSED counts
        // like a RUN edge so the lost time equals the cycles spent paused.
        if (stop) begin
          state_d = ST_IDLE;
        end else if (pause) begin
          state_d = ST_PAUSED;
        end else begin
          state_d = ST_RUN;
          if (pre_q == presc_q) begin
            pre_d  = '0;
            tick_d = 1'b1;
            if (count_q != term_q) begin
              count_d = count_q + WIDTH'(1);
            end else begin
              done_d = 1'b1;
              if (mode_q) begin
                count_d = load_q;
              end else begin
                state_d = ST_DONE;
              end
            end
          end else begin
            pre_d = pre_q + PRE_W'(1);
          end
        end
      end
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      count_q <= '0;
      load_q  <= '0;
      term_q  <= '0;
      pre_q   <= '0;
      presc_q <= '0;
      mode_q  <= 1'b0;
      tick_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      load_q  <= load_d;
      term_q  <= term_d;
      pre_q   <= pre_d;
      presc_q <= presc_d;
      mode_q  <= mode_d;
      tick_q  <= tick_d;
      done_q  <= done_d;
    end
  end

  assign count_out = count_q;
  assign tick      = tick_q;
  assign done      = done_q;
  assign state     = state_q;
  assign busy      = (state_q == ST_RUN) || (state_q == ST_PAUSED);

endmodule

// File: tb/tb_upcounter_ctrl.sv
// Directed self-checking bench for upcounter_ctrl.
module tb_upcounter_ctrl;

  logic       clock;
  logic       reset;
  logic       start, stop, pause, mode;
  logic [3:0] load_val, term_val;
  logic [7:0] prescale;
  logic [3:0] count_out;
  logic       tick, done, busy;
  logic [1:0] state;

  int checks   = 0;
  int failures = 0;

  upcounter_ctrl #(.WIDTH(4), .PRE_W(8)) dut (
    .clock    (clock),
    .reset    (reset),
    .start    (start),
    .stop     (stop),
    .pause    (pause),
    .mode     (mode),
    .load_val (load_val),
    .term_val (term_val),
    .prescale (prescale),
    .count_out(count_out),
    .tick     (tick),
    .done     (done),
    .busy     (busy),
    .state    (state)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clock);
    #1;
  endtask

  task automatic check_all(input string tag, input logic [3:0] c, input logic t,
                           input logic d, input logic [1:0] s, input logic b);
    check({tag, ".count"}, {4'd0, count_out}, {4'd0, c});
    check({tag, ".tick"},  {7'd0, tick},      {7'd0, t});
    check({tag, ".done"},  {7'd0, done},      {7'd0, d});
    check({tag, ".state"}, {6'd0, state},     {6'd0, s});
    check({tag, ".busy"},  {7'd0, busy},      {7'd0, b});
  endtask

  initial begin
    logic [3:0] ar_cnt [4];
    ar_cnt[0] = 4'd15; ar_cnt[1] = 4'd0; ar_cnt[2] = 4'd1; ar_cnt[3] = 4'd14;

    reset = 1'b0; start = 0; stop = 0; pause = 0; mode = 0;
    load_val = 0; term_val = 0; prescale = 0;
    #12;
    check_all("reset", 4'd0, 0, 0, 2'd0, 0);
    reset = 1'b1;
    cyc();
    check_all("idle", 4'd0, 0, 0, 2'd0, 0);

    // One-shot 3 -> 6, prescale 0
    load_val = 4'd3; term_val = 4'd6; prescale = 8'd0; mode = 1'b0; start = 1'b1;
    cyc();
    start = 1'b0;
    check_all("os_start", 4'd3, 0, 0, 2'd1, 1);
    cyc(); check_all("os_c4", 4'd4, 1, 0, 2'd1, 1);
    cyc(); check_all("os_c5", 4'd5, 1, 0, 2'd1, 1);
    cyc(); check_all("os_c6", 4'd6, 1, 0, 2'd1, 1);
    cyc(); check_all("os_done", 4'd6, 1, 1, 2'd3, 0);
    cyc(); check_all("os_hold", 4'd6, 0, 0, 2'd3, 0);

    // Auto-reload 14 -> 1, prescale 2, restart from DONE; inputs scrambled after start
    load_val = 4'd14; term_val = 4'd1; prescale = 8'd2; mode = 1'b1; start = 1'b1;
    cyc();
    start = 1'b0; load_val = 4'd0; term_val = 4'd0; prescale = 8'd0; mode = 1'b0;
    check_all("ar_start", 4'd14, 0, 0, 2'd1, 1);
    for (int i = 0; i < 4; i++) begin
      cyc(); check_all("ar_gap1", (i == 0) ? 4'd14 : ar_cnt[i-1], 0, 0, 2'd1, 1);
      cyc(); check_all("ar_gap2", (i == 0) ? 4'd14 : ar_cnt[i-1], 0, 0, 2'd1, 1);
      cyc(); check_all("ar_tick", ar_cnt[i], 1, (i == 3), 2'd1, 1);
    end

    // Start ignored in RUN, then stop on the edge a tick is due
    load_val = 4'd5; start = 1'b1;
    cyc(); check_all("run_start_ign", 4'd14, 0, 0, 2'd1, 1);
    start = 1'b0;
    cyc(); check_all("pre_stop", 4'd14, 0, 0, 2'd1, 1);
    stop = 1'b1;
    cyc(); check_all("stop_tick", 4'd14, 0, 0, 2'd0, 0);
    stop = 1'b0;
    cyc(); check_all("stop_idle", 4'd14, 0, 0, 2'd0, 0);

    // Pause mid-prescale, prescale 3
    load_val = 4'd2; term_val = 4'd15; prescale = 8'd3; mode = 1'b0; start = 1'b1;
    cyc(); start = 1'b0;
    check_all("ps_start", 4'd2, 0, 0, 2'd1, 1);
    cyc(); cyc();
    pause = 1'b1;
    for (int i = 0; i < 5; i++) begin
      cyc(); check_all("ps_frozen", 4'd2, 0, 0, 2'd2, 1);
    end
    pause = 1'b0;
    cyc(); check_all("ps_release", 4'd2, 0, 0, 2'd1, 1);
    cyc(); check_all("ps_tick", 4'd3, 1, 0, 2'd1, 1);
    cyc(); cyc(); cyc();
    check_all("ps_gap", 4'd3, 0, 0, 2'd1, 1);
    cyc(); check_all("ps_tick2", 4'd4, 1, 0, 2'd1, 1);

    // Pause on the edge a tick is due: tick lands on the release edge
    cyc(); cyc(); cyc();
    pause = 1'b1;
    cyc(); check_all("pt_pause", 4'd4, 0, 0, 2'd2, 1);
    pause = 1'b0;
    cyc(); check_all("pt_tick", 4'd5, 1, 0, 2'd1, 1);

    stop = 1'b1;
    cyc(); check_all("stop_run", 4'd5, 0, 0, 2'd0, 0);
    stop = 1'b0;

    // load == term, prescale 1: done on first tick at k+2
    load_val = 4'd9; term_val = 4'd9; prescale = 8'd1; mode = 1'b0; start = 1'b1;
    cyc(); start = 1'b0;
    check_all("eq_start", 4'd9, 0, 0, 2'd1, 1);
    cyc(); check_all("eq_k1", 4'd9, 0, 0, 2'd1, 1);
    cyc(); check_all("eq_done", 4'd9, 1, 1, 2'd3, 0);
    cyc(); check_all("eq_hold", 4'd9, 0, 0, 2'd3, 0);

    // Asynchronous reset mid-run with count 7
    load_val = 4'd7; term_val = 4'd12; prescale = 8'd5; mode = 1'b0; start = 1'b1;
    cyc(); start = 1'b0;
    check_all("rr_run", 4'd7, 0, 0, 2'd1, 1);
    #3 reset = 1'b0;
    #1 check_all("rr_async", 4'd0, 0, 0, 2'd0, 0);
    cyc(); check_all("rr_held", 4'd0, 0, 0, 2'd0, 0);
    #2 reset = 1'b1;
    cyc(); check_all("rr_idle", 4'd0, 0, 0, 2'd0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
